main: RTL and testbench

//   Registered 4-to-1 selector for WIDTH-bit data words (default 2 bits).

---
 rtl/main_pkg.sv | 11 +
 rtl/main_mux4.sv | 27 ++
 rtl/main.sv | 35 +++
 tb/tb_main.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared select codes and types for the registered 4:1 selector.
package main_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : main_pkg

// File: rtl/main_mux4.sv
// Combinational 4:1 word mux. An unknown select code yields zero rather than
// passing X through from the data inputs.
module main_mux4
  import main_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = '0;
    endcase
  end

endmodule : main_mux4

// File: rtl/main.sv
// Registered 4:1 selector: the mux output is captured every rising edge.
// There is no handshake and no enable, so data changes one cycle after its inputs.
module main
  import main_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mux_y;

  main_mux4 #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .y   (mux_y)
  );

  // Only the mux output is flopped; inputs pass straight through the mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= mux_y;
  end

endmodule : main

// File: tb/tb_main.sv
// Directed bench for the registered 4:1 selector; inputs change on the falling
// edge and data is checked on the falling edge or just after asynchronous events.
module tb_main;
  import main_pkg::*;

  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic [W-1:0] a, b, c, d;
  sel_t         sel;
  logic [W-1:0] data;

  int tests  = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  main #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .sel  (sel),
    .data (data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mux(input sel_t s, input logic [W-1:0] ia,
                                           input logic [W-1:0] ib, input logic [W-1:0] ic,
                                           input logic [W-1:0] id);
    case (s)
      2'b00:   return ia;
      2'b01:   return ib;
      2'b10:   return ic;
      2'b11:   return id;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] expv);
    tests++;
    assert (data === expv) else begin
      errors++;
      $error("FAIL %s: data=%b expected=%b", tag, data, expv);
    end
  endtask

  task automatic drive_sel(input sel_t s);
    @(negedge clk);
    sel = s;
  endtask

  task automatic drive_all(input sel_t s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [W-1:0] ic, input logic [W-1:0] id);
    @(negedge clk);
    sel = s;
    a   = ia;
    b   = ib;
    c   = ic;
    d   = id;
  endtask

  initial begin
    rst = 1'b1;
    sel = 2'bxx;
    a   = 2'b00;
    b   = 2'b10;
    c   = 2'b01;
    d   = 2'b11;

    // 1: reset held for 100 ns with sel undriven
    #1;
    check("rst_initial", 2'b00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("rst_hold", 2'b00);
    end

    // 2/3: fixed select map, one cycle of latency
    drive_sel(SEL_A);
    rst = 1'b0;
    #1;
    check("rst_release_no_edge", 2'b00);
    drive_sel(SEL_B);
    check("sel_a", 2'b00);
    #1;
    check("no_bypass_b", 2'b00);
    drive_sel(SEL_C);
    check("sel_b", 2'b10);
    drive_sel(SEL_D);
    check("sel_c", 2'b01);
    drive_sel(SEL_A);
    check("sel_d", 2'b11);
    @(negedge clk);
    check("sel_a_again", 2'b00);

    // 4: random sweep against the reference mux
    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] ra, rb, rc, rd;
      sel_t         rs;
      rs = sel_t'(i % 4);
      ra = W'($urandom_range(0, 3));
      rb = W'($urandom_range(0, 3));
      rc = W'($urandom_range(0, 3));
      rd = W'($urandom_range(0, 3));
      drive_all(rs, ra, rb, rc, rd);
      if (exp_q.size() != 0) check("sweep", exp_q.pop_front());
      exp_q.push_back(ref_mux(rs, ra, rb, rc, rd));
    end
    @(negedge clk);
    check("sweep_last", exp_q.pop_front());

    // 5: asynchronous reset between edges
    drive_all(SEL_D, 2'b00, 2'b10, 2'b01, 2'b11);
    @(negedge clk);
    check("d_steady", 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 2'b00);
    @(negedge clk);
    check("rst_over_edge", 2'b00);
    rst = 1'b0;
    #1;
    check("rst_release_hold", 2'b00);
    @(negedge clk);
    check("after_rst_d", 2'b11);

    // 6: selected input changes while sel stays the same
    drive_all(SEL_B, 2'b00, 2'b10, 2'b01, 2'b11);
    @(negedge clk);
    check("sel_b_before", 2'b10);
    sel = SEL_B;
    b   = 2'b01;
    #1;
    check("b_change_no_bypass", 2'b10);
    @(negedge clk);
    check("b_change", 2'b01);

    // sel change and input change in the same cycle
    sel = SEL_C;
    c   = 2'b10;
    @(negedge clk);
    check("sel_and_c_change", 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_main
